// File: rtl/pac_slot_master.sv
// pac_slot_master: MSX slot bus initiator for ESE PAC reads, writes and SRAM unlock/lock sequences.
// Define PAC_UNLOCK_EN to enable ops 10/11; otherwise they are rejected with RSP_ERR.
module pac_slot_master #(
  parameter int STROBE_CYCLES = 3
) (
  input  logic        SLT_CLOCK,
  input  logic        SLT_RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [15:0] CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_ERR,
  output logic        UNLOCKED,
  output logic        SLT_SLTSL,
  output logic        SLT_RDn,
  output logic        SLT_WEn,
  output logic [15:0] SLT_A,
  output logic [7:0]  SLT_D_OUT,
  output logic        SLT_D_OE,
  input  logic [7:0]  SLT_D_IN
);
`ifdef PAC_UNLOCK_EN
  localparam bit UNLOCK = 1'b1;
`else
  localparam bit UNLOCK = 1'b0;
`endif
  // The responder samples strobes on a clock edge, so fewer than two cycles is unsafe.
  localparam int SC = (STROBE_CYCLES < 2) ? 2 : STROBE_CYCLES;
  localparam int CW = $clog2(SC);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q, seq_q;
  logic [7:0]    d2_q, sha_q, shb_q;
  logic          acc, rej;
  assign acc = CMD_VALID && CMD_READY;
  assign rej = CMD_OP[1] && !UNLOCK;
  always_ff @(posedge SLT_CLOCK or posedge SLT_RESET) begin
    if (SLT_RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      seq_q     <= 1'b0;
      d2_q      <= 8'h00;
      sha_q     <= 8'h00;
      shb_q     <= 8'h00;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 8'h00;
      RSP_ERR   <= 1'b0;
      UNLOCKED  <= 1'b0;
      SLT_SLTSL <= 1'b1;
      SLT_RDn   <= 1'b1;
      SLT_WEn   <= 1'b1;
      SLT_A     <= 16'h0000;
      SLT_D_OUT <= 8'h00;
      SLT_D_OE  <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      UNLOCKED  <= (sha_q == 8'h4D) && (shb_q == 8'h69);
      case (state_q)
        IDLE: begin
          CMD_READY <= !acc;
          if (acc && rej) begin
            state_q   <= RESP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
          end else if (acc) begin
            state_q   <= SETUP;
            wr_q      <= CMD_OP != 2'b00;
            seq_q     <= CMD_OP[1];
            d2_q      <= CMD_OP[0] ? 8'h00 : 8'h69;
            SLT_SLTSL <= 1'b0;
            SLT_D_OE  <= CMD_OP != 2'b00;
            SLT_A     <= CMD_OP[1] ? 16'h5FFE : CMD_ADDR;
            SLT_D_OUT <= CMD_OP == 2'b10 ? 8'h4D : CMD_OP == 2'b11 ? 8'h00 :
                         CMD_OP == 2'b01 ? CMD_WDATA : SLT_D_OUT;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= '0;
          SLT_RDn <= wr_q;
          SLT_WEn <= !wr_q;
        end
        STROBE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(SC - 1)) begin
            state_q <= HOLD;
            SLT_RDn <= 1'b1;
            SLT_WEn <= 1'b1;
            if (!wr_q) RSP_RDATA <= SLT_D_IN;
          end
        end
        HOLD: begin
          state_q   <= RECOVER;
          SLT_SLTSL <= 1'b1;
          SLT_D_OE  <= 1'b0;
          if (wr_q && SLT_A == 16'h5FFE) sha_q <= SLT_D_OUT;
          if (wr_q && SLT_A == 16'h5FFF) shb_q <= SLT_D_OUT;
        end
        RECOVER: begin
          if (seq_q) begin
            state_q   <= SETUP;
            seq_q     <= 1'b0;
            SLT_A     <= 16'h5FFF;
            SLT_D_OUT <= d2_q;
            SLT_SLTSL <= 1'b0;
            SLT_D_OE  <= 1'b1;
          end else begin
            state_q   <= RESP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          CMD_READY <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pac_slot_master.sv
// tb_pac_slot_master: table-driven command checks plus reset and bus-timing sequences.
module tb_pac_slot_master;
  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready;
  logic [1:0]  cmd_op = 0;
  logic [15:0] cmd_addr = 0;
  logic [7:0]  cmd_wdata = 0, slt_din = 0;
  logic        rsp_valid, rsp_err, unlocked;
  logic [7:0]  rsp_rdata, slt_dout;
  logic        sltsl, rdn, wen, d_oe;
  logic [15:0] slt_a;
  int checks = 0, errors = 0;

  pac_slot_master dut (
    .SLT_CLOCK(clk), .SLT_RESET(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_OP(cmd_op), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .RSP_VALID(rsp_valid),
    .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err), .UNLOCKED(unlocked), .SLT_SLTSL(sltsl),
    .SLT_RDn(rdn), .SLT_WEn(wen), .SLT_A(slt_a), .SLT_D_OUT(slt_dout), .SLT_D_OE(d_oe),
    .SLT_D_IN(slt_din));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op; logic [15:0] addr; logic [7:0] wd, din;
    int sl, we, rd, rsp_at; logic err; logic [7:0] rdata; logic unl;
    int wn; logic [15:0] a0, a1; logic [7:0] d0, d1;
  } vec_t;

  function automatic vec_t v(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd, din,
                             input int sl, we, rd, rsp_at, input logic err, input logic [7:0] rdata,
                             input logic unl, input int wn, input logic [15:0] a0, input logic [7:0] d0,
                             input logic [15:0] a1, input logic [7:0] d1);
    vec_t r;
    r.op = op; r.addr = addr; r.wd = wd; r.din = din; r.sl = sl; r.we = we; r.rd = rd;
    r.rsp_at = rsp_at; r.err = err; r.rdata = rdata; r.unl = unl; r.wn = wn;
    r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-command observations collected by run_cmd
  int sl_n, we_n, rd_n, rsp_n, rsp_at, unstable, oe_bad, wn;
  logic [7:0]  r_rdata;
  logic        r_err, r_unl, accepted;
  logic [15:0] wa[4];
  logic [7:0]  wdl[4];

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] din);
    logic p_sl, p_st;
    logic [15:0] a0;
    logic [7:0] d0;
    int n;
    sl_n = 0; we_n = 0; rd_n = 0; rsp_n = 0; rsp_at = -1; unstable = 0; oe_bad = 0; wn = 0;
    r_rdata = 0; r_err = 0; r_unl = 0; p_sl = 1; p_st = 1; a0 = 0; d0 = 0;
    slt_din = din;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    accepted = cmd_ready;
    if (!accepted) begin
      cmd_valid = 0;
      chk("accept_timeout", 0, 1);
      return;
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      cmd_valid = 0;
      if (!sltsl) begin
        sl_n++;
        if (p_sl) begin a0 = slt_a; d0 = slt_dout; end
        else if (slt_a !== a0 || (op != 0 && slt_dout !== d0)) unstable++;
        if (d_oe !== (op != 0)) oe_bad++;
      end else if (d_oe) oe_bad++;
      if (!wen) we_n++;
      if (!rdn) rd_n++;
      if (!(wen && rdn) && p_st && wn < 4) begin
        wa[wn] = slt_a; wdl[wn] = wen ? 8'h00 : slt_dout; wn++;
      end
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_at < 0) begin rsp_at = k; r_rdata = rsp_rdata; r_err = rsp_err; r_unl = unlocked; end
      end
      p_sl = sltsl; p_st = wen && rdn;
    end
  endtask

  vec_t tv[11];

  initial begin
    tv[0]  = v(2'd1, 16'h4123, 8'hA5, 8'h00, 5, 3, 0, 7, 0, 8'h00, 0, 1, 16'h4123, 8'hA5, 0, 0);
    tv[1]  = v(2'd0, 16'h4000, 8'h00, 8'h3C, 5, 0, 3, 7, 0, 8'h3C, 0, 1, 16'h4000, 8'h00, 0, 0);
    tv[2]  = v(2'd0, 16'h8000, 8'h77, 8'h81, 5, 0, 3, 7, 0, 8'h81, 0, 1, 16'h8000, 8'h00, 0, 0);
    tv[3]  = v(2'd1, 16'h5FFE, 8'h4D, 8'h00, 5, 3, 0, 7, 0, 8'h81, 0, 1, 16'h5FFE, 8'h4D, 0, 0);
    tv[4]  = v(2'd1, 16'h5FFF, 8'h69, 8'h00, 5, 3, 0, 7, 0, 8'h81, 1, 1, 16'h5FFF, 8'h69, 0, 0);
    tv[5]  = v(2'd1, 16'h5FFF, 8'h00, 8'h00, 5, 3, 0, 7, 0, 8'h81, 0, 1, 16'h5FFF, 8'h00, 0, 0);
    tv[6]  = v(2'd1, 16'h5FFF, 8'h69, 8'h00, 5, 3, 0, 7, 0, 8'h81, 1, 1, 16'h5FFF, 8'h69, 0, 0);
    tv[7]  = v(2'd0, 16'h4000, 8'h00, 8'h5A, 5, 0, 3, 7, 0, 8'h5A, 1, 1, 16'h4000, 8'h00, 0, 0);
`ifdef PAC_UNLOCK_EN
    tv[8]  = v(2'd3, 16'h1234, 8'hEE, 8'h00, 10, 6, 0, 13, 0, 8'h5A, 0, 2, 16'h5FFE, 8'h00, 16'h5FFF, 8'h00);
    tv[9]  = v(2'd2, 16'h0000, 8'h00, 8'h00, 10, 6, 0, 13, 0, 8'h5A, 1, 2, 16'h5FFE, 8'h4D, 16'h5FFF, 8'h69);
`else
    tv[8]  = v(2'd3, 16'h1234, 8'hEE, 8'h00, 0, 0, 0, 1, 1, 8'h5A, 1, 0, 0, 0, 0, 0);
    tv[9]  = v(2'd2, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h5A, 1, 0, 0, 0, 0, 0);
`endif
    tv[10] = v(2'd1, 16'h7FFF, 8'h12, 8'h00, 5, 3, 0, 7, 0, 8'h5A, 1, 1, 16'h7FFF, 8'h12, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_sltsl", sltsl, 1); chk("rst_rdn", rdn, 1); chk("rst_wen", wen, 1);
    chk("rst_a", slt_a, 16'h0000); chk("rst_dout", slt_dout, 8'h00); chk("rst_oe", d_oe, 0);
    chk("rst_ready", cmd_ready, 0); chk("rst_rspv", rsp_valid, 0); chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_err", rsp_err, 0); chk("rst_unl", unlocked, 0);
    rst = 0;
    #1 chk("ready_before_clk", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1);

    for (int i = 0; i < 11; i++) begin
      run_cmd(tv[i].op, tv[i].addr, tv[i].wd, tv[i].din);
      if (accepted) begin
        chk($sformatf("v%0d_sltsl_clks", i), sl_n, tv[i].sl);
        chk($sformatf("v%0d_wen_clks", i), we_n, tv[i].we);
        chk($sformatf("v%0d_rdn_clks", i), rd_n, tv[i].rd);
        chk($sformatf("v%0d_rsp_at", i), rsp_at, tv[i].rsp_at);
        chk($sformatf("v%0d_rsp_count", i), rsp_n, 1);
        chk($sformatf("v%0d_err", i), r_err, tv[i].err);
        chk($sformatf("v%0d_rdata", i), r_rdata, tv[i].rdata);
        chk($sformatf("v%0d_unlocked", i), r_unl, tv[i].unl);
        chk($sformatf("v%0d_stable", i), unstable, 0);
        chk($sformatf("v%0d_oe", i), oe_bad, 0);
        chk($sformatf("v%0d_cycles", i), wn, tv[i].wn);
        if (wn > 0) begin
          chk($sformatf("v%0d_addr0", i), wa[0], tv[i].a0);
          chk($sformatf("v%0d_data0", i), wdl[0], tv[i].d0);
        end
        if (wn > 1) begin
          chk($sformatf("v%0d_addr1", i), wa[1], tv[i].a1);
          chk($sformatf("v%0d_data1", i), wdl[1], tv[i].d1);
        end
      end
    end

    // Reset pulsed while a write strobe is active
    @(negedge clk);
    cmd_valid = 1;
`ifdef PAC_UNLOCK_EN
    cmd_op = 2'd2;
`else
    cmd_op = 2'd1; cmd_addr = 16'h5FFE; cmd_wdata = 8'h11;
`endif
    begin
      int n;
      n = 0;
      while (wen && n < 20) begin @(negedge clk); cmd_valid = 0; n++; end
      cmd_valid = 0;
      chk("midrst_strobe_seen", wen, 0);
      #2 rst = 1;
      #1;
      chk("midrst_sltsl", sltsl, 1); chk("midrst_wen", wen, 1); chk("midrst_rdn", rdn, 1);
      chk("midrst_oe", d_oe, 0); chk("midrst_rspv", rsp_valid, 0); chk("midrst_unl", unlocked, 0);
      @(negedge clk);
      rst = 0;
      n = 0;
      for (int k = 0; k < 16; k++) begin @(negedge clk); if (rsp_valid) n++; end
      chk("midrst_no_rsp", n, 0);
      chk("midrst_unl_after", unlocked, 0);
      chk("midrst_ready", cmd_ready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
